// File: rtl/ntt_n.sv
// Iterative radix-2 DIF number-theoretic transform with one butterfly per cycle.
// Twiddle tables, q and n_inv persist between transforms; coefficients are transformed in place.
module ntt_n #(
  parameter int DATA_SIZE_ARB = 32,
  parameter int RING_DEPTH    = 10,
  parameter int PE_DEPTH      = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_w,
  input  logic                     load_data,
  input  logic                     start,
  input  logic                     start_intt,
  input  logic [DATA_SIZE_ARB-1:0] din,
  output logic                     done,
  output logic [DATA_SIZE_ARB-1:0] dout
);

  localparam int W       = DATA_SIZE_ARB;
  localparam int N       = 1 << RING_DEPTH;
  localparam int HALF    = N / 2;
  localparam int W_DEPTH = (((1 << (RING_DEPTH - PE_DEPTH)) - 1) + PE_DEPTH) << PE_DEPTH;
  localparam int TA      = $clog2(2 * W_DEPTH);
  localparam int CW      = $clog2(2 * W_DEPTH + N + 2);
  localparam int SW      = $clog2(RING_DEPTH + 1);

  localparam logic [CW-1:0]         CNT_TW_END  = CW'(2 * W_DEPTH);
  localparam logic [CW-1:0]         CNT_LW_LAST = CW'(2 * W_DEPTH + 1);
  localparam logic [CW-1:0]         CNT_N_LAST  = CW'(N - 1);
  localparam logic [CW-1:0]         CNT_N       = CW'(N);
  localparam logic [RING_DEPTH-1:0] BF_LAST     = RING_DEPTH'(HALF - 1);
  localparam logic [SW-1:0]         STAGE_LAST  = SW'(RING_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_D, NTT, INTT_SCALE, OUT} state_t;

  state_t state, state_next;

  logic [CW-1:0]         cnt;
  logic [SW-1:0]         stage;
  logic [RING_DEPTH-1:0] bf;
  logic                  inverse;

  logic [W-1:0] tw_mem   [2*W_DEPTH];
  logic [W-1:0] data_mem [N];
  logic [W-1:0] q_reg;
  logic [W-1:0] n_inv_reg;

  logic [RING_DEPTH-1:0] span_mask, addr_a, addr_b, data_idx;
  logic [TA-1:0]         tw_addr;
  logic [W-1:0]          op_a, op_b, tw, sum_mod, diff_mod, prod_mod, scale_mod;
  logic [W:0]            sum_ext;
  logic [2*W-1:0]        prod_full, scale_full;

  // First table word of each stage: rows halve until they reach the PE row width, then stay fixed.
  function automatic int tw_base(input logic [SW-1:0] s);
    int si;
    si = int'(s);
    if (si <= RING_DEPTH - PE_DEPTH)
      return N - (N >> si);
    else
      return (N - (1 << PE_DEPTH)) + ((si - (RING_DEPTH - PE_DEPTH)) << PE_DEPTH);
  endfunction

  function automatic logic [RING_DEPTH-1:0] bit_rev(input logic [RING_DEPTH-1:0] a);
    logic [RING_DEPTH-1:0] r;
    for (int i = 0; i < RING_DEPTH; i++) r[i] = a[RING_DEPTH-1-i];
    return r;
  endfunction

  always_comb begin
    span_mask  = RING_DEPTH'((HALF >> stage) - 1);
    addr_a     = ((bf & ~span_mask) << 1) | (bf & span_mask);
    addr_b     = addr_a | (span_mask + RING_DEPTH'(1));
    tw_addr    = TA'(tw_base(stage) + int'(bf & span_mask) + (inverse ? W_DEPTH : 0));
    data_idx   = cnt[RING_DEPTH-1:0];
    op_a       = data_mem[addr_a];
    op_b       = data_mem[addr_b];
    tw         = tw_mem[tw_addr];
    sum_ext    = {1'b0, op_a} + {1'b0, op_b};
    sum_mod    = (sum_ext >= {1'b0, q_reg}) ? W'(sum_ext - {1'b0, q_reg}) : W'(sum_ext);
    // When a < b the true difference a-b+q lies in [0,q), so W-bit wraparound is exact.
    diff_mod   = (op_a >= op_b) ? (op_a - op_b) : (op_a + (q_reg - op_b));
    prod_full  = {{W{1'b0}}, diff_mod} * {{W{1'b0}}, tw};
    prod_mod   = W'(prod_full % {{W{1'b0}}, q_reg});
    scale_full = {{W{1'b0}}, data_mem[data_idx]} * {{W{1'b0}}, n_inv_reg};
    scale_mod  = W'(scale_full % {{W{1'b0}}, q_reg});
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load_w)                    state_next = LOAD_W;
        else if (load_data)            state_next = LOAD_D;
        else if (start || start_intt)  state_next = NTT;
      end
      LOAD_W:     if (cnt == CNT_LW_LAST) state_next = IDLE;
      LOAD_D:     if (cnt == CNT_N_LAST)  state_next = IDLE;
      NTT:        if (stage == STAGE_LAST && bf == BF_LAST)
                    state_next = inverse ? INTT_SCALE : OUT;
      INTT_SCALE: if (cnt == CNT_N_LAST)  state_next = OUT;
      OUT:        if (cnt == CNT_N)       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      stage   <= '0;
      bf      <= '0;
      inverse <= 1'b0;
      done    <= 1'b0;
      dout    <= '0;
    end else begin
      state <= state_next;
      done  <= (state != OUT) && (state_next == OUT);
      dout  <= '0;
      case (state)
        IDLE: begin
          cnt   <= '0;
          stage <= '0;
          bf    <= '0;
          // Forward wins when both start pulses coincide.
          if (state_next == NTT) inverse <= ~start;
        end
        LOAD_W, LOAD_D: cnt <= cnt + CW'(1);
        NTT: begin
          if (bf == BF_LAST) begin
            bf    <= '0;
            stage <= stage + SW'(1);
          end else begin
            bf <= bf + RING_DEPTH'(1);
          end
        end
        INTT_SCALE: cnt <= (cnt == CNT_N_LAST) ? '0 : cnt + CW'(1);
        OUT: begin
          if (cnt != CNT_N) begin
            dout <= data_mem[bit_rev(data_idx)];
            cnt  <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Storage carries no reset so tables survive a reset and map onto plain RAM.
  always_ff @(posedge clk) begin
    case (state)
      LOAD_W: begin
        if (cnt < CNT_TW_END)       tw_mem[TA'(cnt)] <= din;
        else if (cnt == CNT_TW_END) q_reg <= din;
        else                        n_inv_reg <= din;
      end
      LOAD_D: data_mem[data_idx] <= din;
      NTT: begin
        data_mem[addr_a] <= sum_mod;
        data_mem[addr_b] <= prod_mod;
      end
      INTT_SCALE: data_mem[data_idx] <= scale_mod;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ntt_n.sv
// Directed bench for ntt_n at N=4, q=17; expected outputs come from a direct DFT model
// pushed to a scoreboard queue and popped as the result stream appears.
module tb_ntt_n;
  localparam int DW        = 32;
  localparam int RD        = 2;
  localparam int PD        = 1;
  localparam int N         = 4;
  localparam int WD        = 4;
  localparam int Q         = 17;
  localparam int NINV      = 13;
  localparam int OMEGA     = 4;
  localparam int OMEGA_INV = 13;
  localparam int BUDGET    = N / 2 * RD + 2 * N + 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_w = 1'b0, load_data = 1'b0, start = 1'b0, start_intt = 1'b0;
  logic [DW-1:0] din = '0;
  logic          done;
  logic [DW-1:0] dout;

  int n_cmp = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];
  int unsigned   x_vec[N];
  int unsigned   y_vec[N];
  int unsigned   w_tab[WD]    = '{1, 4, 1, 0};
  int unsigned   winv_tab[WD] = '{1, 13, 1, 0};

  always #5 clk = ~clk;

  ntt_n #(.DATA_SIZE_ARB(DW), .RING_DEPTH(RD), .PE_DEPTH(PD)) dut (
    .clk(clk), .reset(reset), .load_w(load_w), .load_data(load_data),
    .start(start), .start_intt(start_intt), .din(din), .done(done), .dout(dout)
  );

  function automatic int unsigned mod_pow(int unsigned b, int unsigned e);
    longint unsigned r = 1;
    for (int unsigned i = 0; i < e; i++) r = (r * b) % Q;
    return int'(r);
  endfunction

  // X[m] = sum x[i] * root^(i*m), scaled by n_inv for the inverse transform.
  function automatic int unsigned dft_point(int unsigned m, bit inv);
    longint unsigned acc = 0;
    int unsigned root = inv ? OMEGA_INV : OMEGA;
    for (int unsigned i = 0; i < N; i++)
      acc = (acc + longint'(x_vec[i]) * mod_pow(root, i * m)) % Q;
    if (inv) acc = (acc * NINV) % Q;
    return int'(acc);
  endfunction

  task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic load_tables();
    @(negedge clk) load_w = 1'b1;
    for (int i = 0; i < 2 * WD + 2; i++) begin
      @(negedge clk);
      load_w = 1'b0;
      if (i < WD)          din = w_tab[i];
      else if (i < 2 * WD) din = winv_tab[i - WD];
      else if (i == 2 * WD) din = Q;
      else                 din = NINV;
    end
    @(negedge clk) din = '0;
  endtask

  task automatic load_coeffs();
    @(negedge clk) load_data = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      load_data = 1'b0;
      din = x_vec[i];
    end
    @(negedge clk) din = '0;
  endtask

  task automatic pulse(bit s, bit si);
    @(negedge clk);
    start = s;
    start_intt = si;
    @(negedge clk);
    start = 1'b0;
    start_intt = 1'b0;
  endtask

  task automatic apply_stimulus(bit s, bit si);
    for (int unsigned m = 0; m < N; m++) exp_q.push_back(dft_point(m, si && !s));
    pulse(s, si);
  endtask

  task automatic check_output(string tag, bit repulse);
    bit got = 0;
    bit dirty = 0;
    logic [DW-1:0] expv;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
      if (dout !== '0) dirty = 1;
      if (repulse) start = (cyc == 1);
    end
    start = 1'b0;
    check({tag, "_done"}, got, 1'b1);
    check({tag, "_quiet"}, dirty, 1'b0);
    for (int m = 0; m < N; m++) begin
      expv = exp_q.size() > 0 ? exp_q.pop_front() : '0;
      if (got) begin
        @(negedge clk);
        if (m == 0) check({tag, "_pulse"}, done, 1'b0);
        check($sformatf("%s_X%0d", tag, m), dout, expv);
      end
    end
    @(negedge clk);
    check({tag, "_tail"}, dout, '0);
  endtask

  task automatic watch_idle(string tag, int cycles);
    int extra = 0;
    bit dirty = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) extra++;
      if (dout !== '0) dirty = 1;
    end
    check({tag, "_no_done"}, extra, 0);
    check({tag, "_dout0"}, dirty, 1'b0);
  endtask

  initial begin
    $display("[TB] ntt_n bench start");
    repeat (2) @(negedge clk);
    check("rst_done", done, 1'b0);
    check("rst_dout", dout, '0);
    reset = 1'b1;

    load_tables();

    x_vec = '{1, 2, 3, 4};
    load_coeffs();
    check("model_fwd0", dft_point(0, 0), 10);
    apply_stimulus(1, 0);
    check_output("fwd_1234", 0);

    x_vec = '{10, 7, 15, 6};
    load_coeffs();
    apply_stimulus(0, 1);
    check_output("inv_10_7_15_6", 0);

    x_vec = '{0, 0, 0, 0};
    load_coeffs();
    apply_stimulus(1, 0);
    check_output("fwd_zero", 0);

    x_vec = '{5, 0, 0, 0};
    load_coeffs();
    apply_stimulus(1, 0);
    check_output("fwd_impulse", 0);

    x_vec = '{1, 2, 3, 4};
    load_coeffs();
    apply_stimulus(1, 1);
    check_output("both_pulses", 0);

    load_coeffs();
    apply_stimulus(1, 0);
    check_output("repulse", 1);
    watch_idle("repulse", 80);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) x_vec[i] = $urandom_range(Q - 1, 0);
      load_coeffs();
      apply_stimulus(1, 0);
      check_output($sformatf("rnd%0d_fwd", r), 0);
      load_coeffs();
      apply_stimulus(0, 1);
      check_output($sformatf("rnd%0d_inv", r), 0);
      for (int m = 0; m < N; m++) y_vec[m] = dft_point(m, 0);
      for (int m = 0; m < N; m++) exp_q.push_back(x_vec[m]);
      x_vec = y_vec;
      load_coeffs();
      pulse(0, 1);
      check_output($sformatf("rnd%0d_round", r), 0);
    end

    // Reset while butterflies are running must suppress the done pulse.
    x_vec = '{1, 2, 3, 4};
    load_coeffs();
    pulse(1, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_dout", dout, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    watch_idle("rst_mid", 80);

    // Reset during the output stream must clear dout without waiting for a clock.
    load_tables();
    load_coeffs();
    pulse(1, 0);
    begin
      bit got = 0;
      for (int cyc = 0; cyc < BUDGET; cyc++) begin
        @(negedge clk);
        if (done) begin
          got = 1;
          break;
        end
      end
      check("rst_out_done", got, 1'b1);
    end
    @(negedge clk);
    check("rst_out_X0", dout, 10);
    reset = 1'b0;
    #1;
    check("rst_out_async", dout, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    watch_idle("rst_out", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
